// File: rtl/pds_pkg.sv
// Shared types and defaults for the packet data switch output arbiters.
// Pure declarations; no clocked logic.
package pds_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      XFER  = 2'd1,
      FLUSH = 2'd2
   } arb_state_e;

   localparam int PDS_NUM_PORTS = 4;
   localparam int PDS_DATA_W    = 8;
   localparam int PDS_MAX_BEATS = 64;
   localparam int PDS_CNT_W     = 16;

   // LSB position of lane idx inside a packed vector of w-bit lanes
   function automatic int slice_lsb(input int idx, input int w);
      return idx * w;
   endfunction

endpackage

// File: rtl/pds_rr_pick.sv
// Rotating-priority picker: first set req bit searching upward from last+1 with wrap.
// Purely combinational, zero latency; no backpressure.
module pds_rr_pick #(
   parameter int NUM_PORTS = 4,
   localparam int IDX_W    = $clog2(NUM_PORTS)
) (
   input  logic [NUM_PORTS-1:0] req,
   input  logic [IDX_W-1:0]     last,
   output logic                 any,
   output logic [IDX_W-1:0]     idx
);

   logic [IDX_W-1:0] w_pos;

   // Walk offsets from lowest to highest priority so the closest hit after last wins.
   always_comb begin
      any   = |req;
      idx   = '0;
      w_pos = '0;
      for (int k = NUM_PORTS; k >= 1; k--) begin
         w_pos = IDX_W'((int'(last) + k) % NUM_PORTS);
         if (req[w_pos]) begin
            idx = w_pos;
         end
      end
   end

endmodule

// File: rtl/pds_out_arbiter.sv
// Packet round-robin arbiter for one switch output; grant held SOP..EOP, 1-cycle arbitration gap.
// Beats pass combinationally (in_ready[grant] = out_ready); runaway packets truncated then flushed.
module pds_out_arbiter
   import pds_pkg::*;
#(
   parameter int NUM_PORTS = PDS_NUM_PORTS,
   parameter int DATA_W    = PDS_DATA_W,
   parameter int MAX_BEATS = PDS_MAX_BEATS,
   parameter int CNT_W     = PDS_CNT_W,
   localparam int SRC_W    = $clog2(NUM_PORTS)
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic [NUM_PORTS-1:0]        in_valid,
   input  logic [NUM_PORTS-1:0]        in_sop,
   input  logic [NUM_PORTS-1:0]        in_eop,
   input  logic [NUM_PORTS*DATA_W-1:0] in_data,
   output logic [NUM_PORTS-1:0]        in_ready,
   output logic                        out_valid,
   output logic                        out_sop,
   output logic                        out_eop,
   output logic [DATA_W-1:0]           out_data,
   input  logic                        out_ready,
   output logic [SRC_W-1:0]            out_src,
   output logic                        err_len,
   output logic [CNT_W-1:0]            pkt_count
);

   localparam int BC_W = $clog2(MAX_BEATS + 1);
   localparam logic [BC_W-1:0] LAST_BEAT = BC_W'(MAX_BEATS - 1);

   arb_state_e       r_state;
   arb_state_e       w_nstate;
   logic [SRC_W-1:0] r_last;
   logic [SRC_W-1:0] r_grant;
   logic [BC_W-1:0]  r_beat_cnt;
   logic [CNT_W-1:0] r_pkt_count;
   logic             r_err_len;

   logic [NUM_PORTS-1:0] w_req;
   logic                 w_any;
   logic [SRC_W-1:0]     w_pick;
   logic [DATA_W-1:0]    w_lane [NUM_PORTS];
   logic                 w_g_valid;
   logic                 w_g_sop;
   logic                 w_g_eop;
   logic [DATA_W-1:0]    w_g_data;
   logic                 w_at_max;
   logic                 w_xfer;

   assign w_req = in_valid & in_sop;

   pds_rr_pick #(
      .NUM_PORTS (NUM_PORTS)
   ) u_pick (
      .req  (w_req),
      .last (r_last),
      .any  (w_any),
      .idx  (w_pick)
   );

   for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_lane
      assign w_lane[gi] = in_data[slice_lsb(gi, DATA_W) +: DATA_W];
   end

   assign w_g_valid = in_valid[r_grant];
   assign w_g_sop   = in_sop[r_grant];
   assign w_g_eop   = in_eop[r_grant];
   assign w_g_data  = w_lane[r_grant];
   assign w_at_max  = (r_beat_cnt == LAST_BEAT);

   always_comb begin
      w_nstate  = r_state;
      out_valid = 1'b0;
      out_sop   = 1'b0;
      out_eop   = 1'b0;
      out_data  = '0;
      in_ready  = '0;
      w_xfer    = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (w_any) begin
               w_nstate = XFER;
            end
         end
         XFER: begin
            out_valid         = w_g_valid;
            out_sop           = w_g_sop;
            out_eop           = w_g_eop | w_at_max;
            out_data          = w_g_data;
            in_ready[r_grant] = out_ready;
            w_xfer            = w_g_valid & out_ready;
            if (w_xfer) begin
               if (w_g_eop) begin
                  w_nstate = IDLE;
               end else if (w_at_max) begin
                  w_nstate = FLUSH;
               end
            end
         end
         FLUSH: begin
            // Tail of a truncated packet is swallowed without reaching the output.
            in_ready[r_grant] = 1'b1;
            if (w_g_valid && w_g_eop) begin
               w_nstate = IDLE;
            end
         end
         default: begin
            w_nstate = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state     <= IDLE;
         r_last      <= SRC_W'(NUM_PORTS - 1);
         r_grant     <= '0;
         r_beat_cnt  <= '0;
         r_pkt_count <= '0;
         r_err_len   <= 1'b0;
      end else begin
         r_state   <= w_nstate;
         r_err_len <= 1'b0;
         if (r_state == IDLE && w_any) begin
            r_grant    <= w_pick;
            r_beat_cnt <= '0;
         end
         if (w_xfer) begin
            r_beat_cnt <= r_beat_cnt + 1'b1;
            if (w_g_eop || w_at_max) begin
               r_last      <= r_grant;
               r_pkt_count <= r_pkt_count + 1'b1;
            end
            if (!w_g_eop && w_at_max) begin
               r_err_len <= 1'b1;
            end
         end
      end
   end

   assign out_src   = (r_state == IDLE) ? '0 : r_grant;
   assign err_len   = r_err_len;
   assign pkt_count = r_pkt_count;

endmodule

// File: tb/tb_pds_out_arbiter.sv
// Randomized bench for pds_out_arbiter against a packet-level round-robin reference model.
module tb_pds_out_arbiter;

   localparam int NP = 4;
   localparam int DW = 8;
   localparam int MB = 64;
   localparam int CW = 16;

   logic              clock = 1'b0;
   logic              reset;
   logic [NP-1:0]     in_valid;
   logic [NP-1:0]     in_sop;
   logic [NP-1:0]     in_eop;
   logic [NP*DW-1:0]  in_data;
   logic [NP-1:0]     in_ready;
   logic              out_valid;
   logic              out_sop;
   logic              out_eop;
   logic [DW-1:0]     out_data;
   logic              out_ready;
   logic [1:0]        out_src;
   logic              err_len;
   logic [CW-1:0]     pkt_count;

   always #5 clock = ~clock;

   pds_out_arbiter #(
      .NUM_PORTS (NP),
      .DATA_W    (DW),
      .MAX_BEATS (MB),
      .CNT_W     (CW)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_sop    (in_sop),
      .in_eop    (in_eop),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_sop   (out_sop),
      .out_eop   (out_eop),
      .out_data  (out_data),
      .out_ready (out_ready),
      .out_src   (out_src),
      .err_len   (err_len),
      .pkt_count (pkt_count)
   );

   typedef struct packed {
      logic          sop;
      logic          eop;
      logic [DW-1:0] data;
   } beat_t;

   typedef struct packed {
      logic [1:0]    src;
      logic          sop;
      logic          eop;
      logic [DW-1:0] data;
   } obs_t;

   beat_t         pq [NP][$];
   int            ppk[NP][$];
   int            plen[$];
   int            pbase[$];
   logic [DW-1:0] dat[$];
   obs_t          exq[$];
   bit            rdy_pat[$];

   int errors = 0, checks = 0, cyc = 0;
   int gap_pct = 0, rdy_pct = 100;
   int mlast = NP - 1, exp_pkts = 0, exp_trunc = 0;
   int n_err = 0, viol = 0, first_c = -1, last_c = -1, beats_seen = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic add_pkt(input int port, input int len);
      beat_t bt;
      logic [DW-1:0] d;
      ppk[port].push_back(plen.size());
      plen.push_back(len);
      pbase.push_back(dat.size());
      for (int b = 0; b < len; b++) begin
         d = DW'($urandom_range(255));
         dat.push_back(d);
         bt.sop  = (b == 0);
         bt.eop  = (b == len - 1);
         bt.data = d;
         pq[port].push_back(bt);
      end
   endtask

   // Packet-level model: every loaded packet is pending at each arbitration point.
   task automatic predict();
      int   found, id, n;
      obs_t o;
      bit   more;
      more = 1'b1;
      while (more) begin
         found = -1;
         for (int k = 1; k <= NP; k++) begin
            if (found < 0 && ppk[(mlast + k) % NP].size() > 0) found = (mlast + k) % NP;
         end
         if (found < 0) begin
            more = 1'b0;
         end else begin
            id = ppk[found].pop_front();
            n  = (plen[id] > MB) ? MB : plen[id];
            for (int b = 0; b < n; b++) begin
               o.src  = 2'(found);
               o.sop  = (b == 0);
               o.eop  = (b == n - 1);
               o.data = dat[pbase[id] + b];
               exq.push_back(o);
            end
            if (plen[id] > MB) exp_trunc++;
            exp_pkts++;
            mlast = found;
         end
      end
   endtask

   function automatic bit all_empty();
      bit e;
      e = 1'b1;
      for (int p = 0; p < NP; p++) if (pq[p].size() > 0) e = 1'b0;
      return e;
   endfunction

   task automatic clear_all();
      for (int p = 0; p < NP; p++) begin
         pq[p].delete();
         ppk[p].delete();
      end
      exq.delete();
      rdy_pat.delete();
   endtask

   task automatic step();
      beat_t         bt;
      obs_t          o;
      logic [11:0]   oval, eval;
      logic [NP-1:0] ex_rdy;
      @(negedge clock);
      for (int p = 0; p < NP; p++) begin
         if (pq[p].size() > 0) begin
            bt = pq[p][0];
            in_valid[p] = bt.sop ? 1'b1 : ($urandom_range(99) >= gap_pct);
            in_sop[p]   = bt.sop;
            in_eop[p]   = bt.eop;
            in_data[p*DW +: DW] = bt.data;
         end else begin
            in_valid[p] = 1'b0;
            in_sop[p]   = 1'b0;
            in_eop[p]   = 1'b0;
            in_data[p*DW +: DW] = '0;
         end
      end
      if (rdy_pat.size() > 0) out_ready = rdy_pat.pop_front();
      else                    out_ready = ($urandom_range(99) < rdy_pct);
      #1;
      cyc++;
      if (err_len) n_err++;
      if ($countones(in_ready) > 1) viol++;
      if (out_valid) begin
         ex_rdy = '0;
         if (out_ready) ex_rdy[out_src] = 1'b1;
         if (in_ready != ex_rdy) viol++;
      end
      for (int p = 0; p < NP; p++) begin
         if (in_valid[p] && in_ready[p]) void'(pq[p].pop_front());
      end
      if (out_valid && out_ready) begin
         o.src = out_src; o.sop = out_sop; o.eop = out_eop; o.data = out_data;
         oval = o;
         beats_seen++;
         if (first_c < 0) first_c = cyc;
         last_c = cyc;
         if (exq.size() == 0) begin
            chk("extra_beat", 32'(oval), 32'(0) | 32'(12'hfff));
         end else begin
            eval = exq.pop_front();
            chk("beat", 32'(oval), 32'(eval));
         end
      end
   endtask

   task automatic run(input string name);
      int c0;
      exp_trunc = 0;
      n_err     = 0;
      viol      = 0;
      first_c   = -1;
      predict();
      c0 = cyc;
      while (!(all_empty() && exq.size() == 0) && (cyc - c0) < 4000) step();
      if ((cyc - c0) >= 4000) begin
         chk({name, "_timeout"}, 32'(exq.size()), 32'(0));
         clear_all();
      end
      repeat (3) step();
      chk({name, "_err_len"}, 32'(n_err), 32'(exp_trunc));
      chk({name, "_pkt_count"}, 32'(pkt_count), 32'(exp_pkts % (1 << CW)));
      chk({name, "_ready"}, 32'(viol), 32'(0));
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset     = 1'b1;
      in_valid  = '0;
      in_sop    = '0;
      in_eop    = '0;
      in_data   = '0;
      out_ready = 1'b0;
      clear_all();
      repeat (2) @(negedge clock);
      reset    = 1'b0;
      mlast    = NP - 1;
      exp_pkts = 0;
   endtask

   initial begin
      int np, port, len;
      do_reset();
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'(0));
      chk("rst_in_ready", 32'(in_ready), 32'(0));
      chk("rst_pkt_count", 32'(pkt_count), 32'(0));
      chk("rst_err_len", 32'(err_len), 32'(0));
      chk("rst_out_src", 32'(out_src), 32'(0));

      // Back-to-back packets from one port: one idle cycle between packets.
      gap_pct = 0; rdy_pct = 100;
      for (int i = 0; i < 3; i++) add_pkt(0, 4);
      run("single_port");
      chk("single_port_span", 32'(last_c - first_c), 32'(13));

      do_reset();
      for (int p = 0; p < NP; p++) add_pkt(p, 2);
      run("all_ports");

      do_reset();
      add_pkt(2, 70);
      run("watchdog");

      do_reset();
      add_pkt(1, 3);
      rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      run("backpressure");

      // Reset while beat 2 of a port-3 packet is on the output.
      exp_trunc = 0;
      add_pkt(3, 5);
      predict();
      beats_seen = 0;
      for (int i = 0; i < 20 && beats_seen < 2; i++) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("midrst_out_valid", 32'(out_valid), 32'(0));
      chk("midrst_in_ready", 32'(in_ready), 32'(0));
      chk("midrst_pkt_count", 32'(pkt_count), 32'(0));
      chk("midrst_out_src", 32'(out_src), 32'(0));
      clear_all();
      mlast    = NP - 1;
      exp_pkts = 0;
      add_pkt(3, 2);
      add_pkt(0, 2);
      run("after_reset");

      do_reset();
      add_pkt(1, 1);
      run("single_beat_a");
      add_pkt(1, 1);
      add_pkt(3, 1);
      run("single_beat_b");

      for (int r = 0; r < 25; r++) begin
         gap_pct = $urandom_range(40);
         rdy_pct = 40 + $urandom_range(60);
         np = 1 + $urandom_range(5);
         for (int i = 0; i < np; i++) begin
            port = $urandom_range(NP - 1);
            len  = ($urandom_range(9) == 0) ? 60 + $urandom_range(10) : 1 + $urandom_range(7);
            add_pkt(port, len);
         end
         run("random");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
